// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: reset PC, queue depth,
// fetch FSM encoding and the queued {pc, instr} entry.
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          FQ_DEPTH         = 2;

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

    function automatic logic [31:0] jump_target(input logic [31:0] pc,
                                                input logic [25:0] idx);
        return {pc[31:28], idx, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/acknowledge channel.
interface fetch_unit_if;

    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemAck;
    logic [31:0] ImemData;

    modport master (output ImemReq, ImemAddr, input  ImemAck, ImemData);
    modport slave  (input  ImemReq, ImemAddr, output ImemAck, ImemData);

endinterface

// File: rtl/fetch_queue.sv
// Two-entry in-order {pc, instr} queue; head entry is registered and
// drives the fetch outputs directly.
module fetch_queue
    import fetch_unit_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_i,
    input  fq_entry_t push_data_i,
    input  logic      pop_i,
    input  logic      flush_all_i,
    input  logic      flush_tail_i,
    output logic      head_val_o,
    output fq_entry_t head_o,
    output logic [1:0] count_next_o
);

    fq_entry_t [FQ_DEPTH-1:0] ent_q, ent_d;
    logic [1:0]               cnt_q, cnt_d;

    always_comb begin
        ent_d = ent_q;
        cnt_d = cnt_q;
        if (flush_all_i) begin
            cnt_d = 2'd0;
        end else begin
            if (pop_i && cnt_q != 2'd0) begin
                ent_d[0] = ent_q[1];
                cnt_d    = cnt_q - 2'd1;
            end
            // Tail flush keeps only a head that is not being consumed.
            if (flush_tail_i)
                cnt_d = (pop_i || cnt_q == 2'd0) ? 2'd0 : 2'd1;
            if (push_i && cnt_d < 2'(FQ_DEPTH)) begin
                ent_d[cnt_d[0]] = push_data_i;
                cnt_d           = cnt_d + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q <= '0;
            cnt_q <= 2'd0;
        end else begin
            ent_q <= ent_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_val_o   = (cnt_q != 2'd0);
    assign head_o       = ent_q[0];
    assign count_next_o = cnt_d;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single outstanding memory request, 2-deep fetch queue,
// jump handling at decode and branch redirect from EX.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         AnyStall,
    input  logic         Jump_IDM1,
    input  logic [25:0]  JumpTgt_IDM1,
    input  logic         BrRedirect_EX,
    input  logic [31:0]  BrRedirectPc_EX,
    fetch_unit_if.master imem,
    output logic [31:0]  Pc_IF,
    output logic [31:0]  FetchData_IF,
    output logic         InstrVal_IF
);

    logic [1:0]  state_q, state_d;
    logic [31:0] fpc_q, fpc_d;
    logic [31:0] addr_q, addr_d;
    logic        ack_acc, consume, jump, flush, push;
    logic [1:0]  occ_nxt;
    fq_entry_t   head, push_data;

    // An ack only counts while a request is in flight.
    assign ack_acc = imem.ImemAck && (state_q != ST_RUN);
    assign consume = InstrVal_IF && !AnyStall;
    assign jump    = consume && Jump_IDM1 && !BrRedirect_EX;
    assign flush   = BrRedirect_EX || jump;
    assign push    = ack_acc && (state_q == ST_WAIT) && !flush;

    assign push_data = '{pc: addr_q, instr: imem.ImemData};

    fetch_queue u_queue (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push),
        .push_data_i  (push_data),
        .pop_i        (consume),
        .flush_all_i  (BrRedirect_EX),
        .flush_tail_i (jump),
        .head_val_o   (InstrVal_IF),
        .head_o       (head),
        .count_next_o (occ_nxt)
    );

    always_comb begin
        fpc_d   = fpc_q;
        addr_d  = addr_q;
        state_d = state_q;
        if (BrRedirect_EX)
            fpc_d = BrRedirectPc_EX;
        else if (jump)
            fpc_d = jump_target(Pc_IF, JumpTgt_IDM1);
        else if (push)
            fpc_d = fpc_q + 32'd4;

        if (state_q != ST_RUN && !ack_acc) begin
            // Request still in flight: a flush turns it into a drop.
            state_d = flush ? ST_DROP : state_q;
        end else begin
            state_d = ST_RUN;
            if (occ_nxt < 2'(FQ_DEPTH)) begin
                state_d = ST_WAIT;
                addr_d  = fpc_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            fpc_q   <= RESET_PC;
            addr_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            addr_q  <= addr_d;
        end
    end

    assign imem.ImemReq  = (state_q != ST_RUN);
    assign imem.ImemAddr = addr_q;
    assign Pc_IF         = head.pc;
    assign FetchData_IF  = head.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: expected fetch PCs are queued as
// stimulus is applied and checked as decode consumes the queue head.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        AnyStall, Jump_IDM1, BrRedirect_EX;
    logic [25:0] JumpTgt_IDM1;
    logic [31:0] BrRedirectPc_EX;
    logic [31:0] Pc_IF, FetchData_IF;
    logic        InstrVal_IF;

    fetch_unit_if imem();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .AnyStall        (AnyStall),
        .Jump_IDM1       (Jump_IDM1),
        .JumpTgt_IDM1    (JumpTgt_IDM1),
        .BrRedirect_EX   (BrRedirect_EX),
        .BrRedirectPc_EX (BrRedirectPc_EX),
        .imem            (imem),
        .Pc_IF           (Pc_IF),
        .FetchData_IF    (FetchData_IF),
        .InstrVal_IF     (InstrVal_IF)
    );

    always #5 clk = ~clk;

    int          chk = 0;
    int          err = 0;
    int          mem_lat = 0;
    logic        stray_ack = 1'b0;
    logic [31:0] sb[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    // Memory: acks a held request after mem_lat extra cycles.
    initial begin
        int lat_cnt;
        lat_cnt = 0;
        imem.ImemAck  = 1'b0;
        imem.ImemData = 32'h0;
        forever begin
            @(negedge clk);
            if (imem.ImemReq === 1'b1) begin
                if (lat_cnt >= mem_lat) begin
                    imem.ImemAck  = 1'b1;
                    imem.ImemData = mem_word(imem.ImemAddr);
                    lat_cnt = 0;
                end else begin
                    imem.ImemAck = 1'b0;
                    lat_cnt++;
                end
            end else begin
                imem.ImemAck  = stray_ack;
                imem.ImemData = 32'hBAD0_0000;
                lat_cnt = 0;
            end
        end
    end

    // Consumed heads are popped from the scoreboard; redirect cycles squash.
    initial begin
        logic [31:0] exp_pc;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && InstrVal_IF && !AnyStall && !BrRedirect_EX) begin
                chk++;
                if (sb.size() == 0) begin
                    err++;
                    $display("FAIL sb_unexpected pc=%h", Pc_IF);
                end else begin
                    exp_pc = sb.pop_front();
                    if (Pc_IF !== exp_pc || FetchData_IF !== mem_word(exp_pc)) begin
                        err++;
                        $display("FAIL sb_head pc=%h data=%h expected pc=%h data=%h",
                                 Pc_IF, FetchData_IF, exp_pc, mem_word(exp_pc));
                    end
                end
            end
        end
    end

    // Decode stalls whenever nothing further is expected.
    task automatic step();
        @(negedge clk);
        Jump_IDM1     = 1'b0;
        BrRedirect_EX = 1'b0;
        AnyStall      = (sb.size() == 0);
    endtask

    task automatic redirect(input logic [31:0] pc);
        step();
        BrRedirect_EX   = 1'b1;
        BrRedirectPc_EX = pc;
        sb.delete();
    endtask

    task automatic drain(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max && sb.size() != 0; i++) begin
            step();
            #3;
        end
        ok = (sb.size() == 0);
    endtask

    task automatic test_reset();
        chk += 5;
        if (InstrVal_IF !== 1'b0) begin err++; $display("FAIL rst_val got=%b want=0", InstrVal_IF); end
        if (Pc_IF !== 32'h0) begin err++; $display("FAIL rst_pc got=%h want=0", Pc_IF); end
        if (FetchData_IF !== 32'h0) begin err++; $display("FAIL rst_data got=%h want=0", FetchData_IF); end
        if (imem.ImemReq !== 1'b0) begin err++; $display("FAIL rst_req got=%b want=0", imem.ImemReq); end
        if (imem.ImemAddr !== 32'h0) begin err++; $display("FAIL rst_addr got=%h want=0", imem.ImemAddr); end
        rst_n = 1'b1;
        step();
        chk++;
        if (imem.ImemReq !== 1'b1 || imem.ImemAddr !== 32'h0) begin
            err++;
            $display("FAIL first_req got=%b/%h want=1/00000000", imem.ImemReq, imem.ImemAddr);
        end
    endtask

    task automatic test_stream();
        repeat (4) step();
        for (int i = 0; i < 6; i++) sb.push_back(32'(i * 4));
        for (int i = 0; i < 6; i++) begin
            step();
            chk++;
            if (InstrVal_IF !== 1'b1) begin
                err++;
                $display("FAIL stream_valid cycle=%0d got=%b want=1", i, InstrVal_IF);
            end
        end
    endtask

    task automatic test_stall();
        bit found, ok;
        mem_lat = 0;
        redirect(32'h0);
        sb.push_back(32'h0);
        sb.push_back(32'h4);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (InstrVal_IF === 1'b1 && Pc_IF === 32'h8 && sb.size() == 0) found = 1'b1;
        end
        chk++;
        if (!found) begin err++; $display("FAIL stall_reach got=none want=pc 00000008"); end
        stray_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            chk += 2;
            if (Pc_IF !== 32'h8) begin err++; $display("FAIL stall_pc got=%h want=00000008", Pc_IF); end
            if (FetchData_IF !== mem_word(32'h8)) begin
                err++; $display("FAIL stall_data got=%h want=%h", FetchData_IF, mem_word(32'h8));
            end
        end
        chk++;
        if (imem.ImemReq !== 1'b0) begin err++; $display("FAIL stall_req got=%b want=0", imem.ImemReq); end
        stray_ack = 1'b0;
        for (int i = 2; i < 6; i++) sb.push_back(32'(i * 4));
        drain(40, ok);
        chk++;
        if (ok !== 1'b1) begin err++; $display("FAIL stall_drain left=%0d want=0", sb.size()); end
    endtask

    task automatic test_redirect();
        bit found, got, forb, ok;
        mem_lat = 4;
        redirect(32'h10);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            if (imem.ImemReq === 1'b1 && imem.ImemAddr === 32'h10) found = 1'b1;
        end
        chk++;
        if (!found) begin err++; $display("FAIL redir_setup got=none want=req 00000010"); end
        BrRedirect_EX   = 1'b1;
        BrRedirectPc_EX = 32'h100;
        sb.delete();
        sb.push_back(32'h100); sb.push_back(32'h104); sb.push_back(32'h108);
        got = 1'b0;
        forb = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            step();
            if (InstrVal_IF === 1'b1 && Pc_IF === 32'h10) forb = 1'b1;
            if (imem.ImemReq === 1'b1 && imem.ImemAddr !== 32'h10) got = 1'b1;
        end
        chk++;
        if (!got || imem.ImemAddr !== 32'h100) begin
            err++; $display("FAIL redir_addr got=%h want=00000100", imem.ImemAddr);
        end
        drain(80, ok);
        chk += 2;
        if (forb !== 1'b0) begin err++; $display("FAIL redir_stale got=pc 00000010 valid want=never"); end
        if (ok !== 1'b1) begin err++; $display("FAIL redir_drain left=%0d want=0", sb.size()); end
    endtask

    task automatic test_jump();
        bit found, ok, seen;
        mem_lat = 0;
        redirect(32'h2000_0040);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            if (InstrVal_IF === 1'b1 && Pc_IF === 32'h2000_0040) found = 1'b1;
        end
        chk++;
        if (!found) begin err++; $display("FAIL jump_reach got=none want=pc 20000040"); end
        sb.push_back(32'h2000_0040);
        AnyStall     = 1'b0;
        Jump_IDM1    = 1'b1;
        JumpTgt_IDM1 = 26'h10;
        #3;
        sb.delete();
        sb.push_back(32'h2000_0040);
        step();
        chk++;
        if (imem.ImemReq !== 1'b1 || imem.ImemAddr !== 32'h2000_0040) begin
            err++; $display("FAIL jump_req got=%b/%h want=1/20000040", imem.ImemReq, imem.ImemAddr);
        end
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (i > 0) step();
            if (InstrVal_IF === 1'b1) begin
                seen = 1'b1;
                chk++;
                if (Pc_IF !== 32'h2000_0040) begin
                    err++; $display("FAIL jump_next got=%h want=20000040", Pc_IF);
                end
            end
        end
        drain(20, ok);
        chk += 2;
        if (seen !== 1'b1) begin err++; $display("FAIL jump_valid got=none want=pc 20000040"); end
        if (ok !== 1'b1) begin err++; $display("FAIL jump_drain left=%0d want=0", sb.size()); end
    endtask

    task automatic test_priority();
        bit found, ok;
        mem_lat = 0;
        redirect(32'h200);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            if (InstrVal_IF === 1'b1 && Pc_IF === 32'h200) found = 1'b1;
        end
        chk++;
        if (!found) begin err++; $display("FAIL prio_reach got=none want=pc 00000200"); end
        AnyStall        = 1'b0;
        Jump_IDM1       = 1'b1;
        JumpTgt_IDM1    = 26'h3F0;
        BrRedirect_EX   = 1'b1;
        BrRedirectPc_EX = 32'h300;
        sb.delete();
        sb.push_back(32'h300); sb.push_back(32'h304);
        step();
        chk++;
        if (imem.ImemReq !== 1'b1 || imem.ImemAddr !== 32'h300) begin
            err++; $display("FAIL prio_addr got=%b/%h want=1/00000300", imem.ImemReq, imem.ImemAddr);
        end
        drain(20, ok);
        chk++;
        if (ok !== 1'b1) begin err++; $display("FAIL prio_drain left=%0d want=0", sb.size()); end
    endtask

    task automatic test_wrap();
        bit ok;
        mem_lat = 0;
        redirect(32'hFFFF_FFFC);
        sb.push_back(32'hFFFF_FFFC); sb.push_back(32'h0); sb.push_back(32'h4);
        step();
        chk++;
        if (imem.ImemReq !== 1'b1 || imem.ImemAddr !== 32'hFFFF_FFFC) begin
            err++; $display("FAIL wrap_first got=%b/%h want=1/fffffffc", imem.ImemReq, imem.ImemAddr);
        end
        step();
        chk++;
        if (imem.ImemReq !== 1'b1 || imem.ImemAddr !== 32'h0) begin
            err++; $display("FAIL wrap_next got=%b/%h want=1/00000000", imem.ImemReq, imem.ImemAddr);
        end
        drain(20, ok);
        chk++;
        if (ok !== 1'b1) begin err++; $display("FAIL wrap_drain left=%0d want=0", sb.size()); end
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        mem_lat = 10;
        redirect(32'h40);
        step();
        chk++;
        if (imem.ImemReq !== 1'b1) begin err++; $display("FAIL rmw_setup got=%b want=1", imem.ImemReq); end
        rst_n = 1'b0;
        #1;
        chk += 5;
        if (InstrVal_IF !== 1'b0) begin err++; $display("FAIL rmw_val got=%b want=0", InstrVal_IF); end
        if (Pc_IF !== 32'h0) begin err++; $display("FAIL rmw_pc got=%h want=0", Pc_IF); end
        if (FetchData_IF !== 32'h0) begin err++; $display("FAIL rmw_data got=%h want=0", FetchData_IF); end
        if (imem.ImemReq !== 1'b0) begin err++; $display("FAIL rmw_req got=%b want=0", imem.ImemReq); end
        if (imem.ImemAddr !== 32'h0) begin err++; $display("FAIL rmw_addr got=%h want=0", imem.ImemAddr); end
        sb.delete();
        repeat (3) step();
        mem_lat = 0;
        rst_n = 1'b1;
        step();
        chk++;
        if (imem.ImemReq !== 1'b1 || imem.ImemAddr !== 32'h0) begin
            err++; $display("FAIL rmw_restart got=%b/%h want=1/00000000", imem.ImemReq, imem.ImemAddr);
        end
        sb.push_back(32'h0); sb.push_back(32'h4);
        drain(20, ok);
        chk++;
        if (ok !== 1'b1) begin err++; $display("FAIL rmw_drain left=%0d want=0", sb.size()); end
    endtask

    initial begin
        rst_n           = 1'b0;
        AnyStall        = 1'b1;
        Jump_IDM1       = 1'b0;
        JumpTgt_IDM1    = 26'h0;
        BrRedirect_EX   = 1'b0;
        BrRedirectPc_EX = 32'h0;
        repeat (3) @(negedge clk);
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_jump();
        test_priority();
        test_wrap();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule
